// File: rtl/max_reduce.sv
// rtl/max_reduce.sv - streaming running max/argmax over IEEE half or single vectors
// Optional MAX_REDUCE_ABS_EN: order elements by magnitude only.
module max_reduce #(
  parameter int BITS      = 16,
  parameter     PRECISION = "HALF",
  parameter int LENGTH    = 8,
  parameter int IDX_BITS  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [BITS-1:0]     a,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS-1:0]     max_value,
  output logic [IDX_BITS-1:0] max_index,
  output logic                nan_seen
);

  localparam int EXP_W  = (PRECISION == "HALF") ? 5 : 8;
  localparam int MANT_W = (PRECISION == "HALF") ? 10 : 23;
  localparam int CNT_W  = IDX_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);
  // Sign 0, exponent all ones, mantissa MSB set: 16'h7E00 / 32'h7FC00000.
  localparam logic [BITS-1:0] QNAN = BITS'(((64'd1 << (EXP_W + 1)) - 64'd1) << (MANT_W - 1));

  if (!((BITS == 16 && PRECISION == "HALF") || (BITS == 32 && PRECISION == "SINGLE")))
    $error("max_reduce: BITS and PRECISION disagree");
  if (LENGTH < 1 || (1 << IDX_BITS) < LENGTH)
    $error("max_reduce: LENGTH out of range for IDX_BITS");

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             a_nan;
  logic             a_greater;

  // Map a value onto an unsigned key whose integer order matches the float order.
  function automatic logic [BITS-1:0] order_key(input logic [BITS-1:0] v);
    logic [BITS-2:0] mag;
    mag = v[BITS-2:0];
`ifdef MAX_REDUCE_ABS_EN
    return {1'b0, mag};
`else
    if (!v[BITS-1] || mag == '0)
      return {1'b1, mag};
    else
      return {1'b0, ~mag};
`endif
  endfunction

  assign a_nan     = (&a[BITS-2 -: EXP_W]) && (|a[MANT_W-1:0]);
  assign a_greater = order_key(a) > order_key(max_value);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = (in_last || LENGTH == 1) ? HOLD : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = (in_last || cnt == LAST_IDX) ? HOLD : ACC;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      max_value <= '0;
      max_index <= '0;
      nan_seen  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (state == IDLE) begin
          max_value <= a_nan ? QNAN : a;
          max_index <= '0;
          nan_seen  <= a_nan;
          cnt       <= CNT_W'(1);
        end else begin
          cnt <= cnt + 1'b1;
          // Once a NaN is latched the result is frozen for the rest of the vector.
          if (!nan_seen) begin
            if (a_nan) begin
              max_value <= QNAN;
              max_index <= cnt[IDX_BITS-1:0];
              nan_seen  <= 1'b1;
            end else if (a_greater) begin
              max_value <= a;
              max_index <= cnt[IDX_BITS-1:0];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_max_reduce.sv
// tb/tb_max_reduce.sv - directed self-checking bench for max_reduce
module tb_max_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic        in_ready, out_valid, nan_seen;
  logic [15:0] a, max_value;
  logic [2:0]  max_index;

  logic        s_in_valid, s_in_last;
  logic        s_in_ready, s_out_valid, s_nan_seen;
  logic [31:0] s_a, s_max_value;
  logic [1:0]  s_max_index;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  max_reduce #(.BITS(16), .PRECISION("HALF"), .LENGTH(8), .IDX_BITS(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .a(a), .out_valid(out_valid), .out_ready(out_ready), .max_value(max_value),
    .max_index(max_index), .nan_seen(nan_seen)
  );

  max_reduce #(.BITS(32), .PRECISION("SINGLE"), .LENGTH(4), .IDX_BITS(2)) u_single (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_last(s_in_last),
    .a(s_a), .out_valid(s_out_valid), .out_ready(1'b1), .max_value(s_max_value),
    .max_index(s_max_index), .nan_seen(s_nan_seen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v, input logic last);
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = v;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic spush(input logic [31:0] v, input logic last);
    chk("s_push_ready", {31'd0, s_in_ready}, 32'd1);
    s_in_valid = 1'b1;
    s_a        = v;
    s_in_last  = last;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [15:0] v, input logic [2:0] idx, input logic nan);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_value"}, {16'd0, max_value}, {16'd0, v});
    chk({tag, "_index"}, {29'd0, max_index}, {29'd0, idx});
    chk({tag, "_nan"}, {31'd0, nan_seen}, {31'd0, nan});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_a = '0;
    step(); step();
    rst = 1'b0;
    step();

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_value", {16'd0, max_value}, 32'd0);
    chk("rst_index", {29'd0, max_index}, 32'd0);
    chk("rst_nan", {31'd0, nan_seen}, 32'd0);

    // Full-length vector, in_last on index LENGTH-1 is a single termination.
    push(16'h3C00, 0); push(16'h4000, 0); push(16'hC000, 0); push(16'h4200, 0);
    push(16'h3C00, 0); push(16'h0000, 0); push(16'h8000, 0);
    chk("len_not_early", {31'd0, out_valid}, 32'd0);
    push(16'h4000, 1);
    result("len8", 16'h4200, 3'd3, 1'b0);
    step();
    chk("len8_done", {31'd0, out_valid}, 32'd0);
    step();
    chk("len8_single", {31'd0, out_valid}, 32'd0);

    // Ties keep the earliest index; +0 and -0 compare equal.
    push(16'h8000, 0); push(16'h0000, 0); push(16'h4000, 0); push(16'h4000, 1);
    result("tie", 16'h4000, 3'd2, 1'b0);
    step();
    push(16'h8000, 0); push(16'h0000, 1);
    result("zero", 16'h8000, 3'd0, 1'b0);
    step();

    // NaN latch, then backpressure with the next element already offered.
    push(16'h3C00, 0);
    out_ready = 1'b0;
    push(16'h7E01, 0); push(16'h7C00, 1);
    result("nan", 16'h7E00, 3'd1, 1'b1);
    in_valid = 1'b1; a = 16'h4400; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      result("stall", 16'h7E00, 3'd1, 1'b1);
    end
    out_ready = 1'b1;
    step();
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    result("after_bp", 16'h4400, 3'd0, 1'b0);
    step();

    // Reset mid-vector discards partial state.
    push(16'h4800, 0); push(16'h4900, 0); push(16'h4A00, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_value", {16'd0, max_value}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    push(16'hC400, 0); push(16'hC000, 1);
    result("neg", 16'hC000, 3'd1, 1'b0);
    step();

    // Single precision lane.
    spush(32'h3F800000, 0); spush(32'hC0400000, 0); spush(32'h40000000, 1);
    chk("single_valid", {31'd0, s_out_valid}, 32'd1);
    chk("single_nan", {31'd0, s_nan_seen}, 32'd0);
`ifdef MAX_REDUCE_ABS_EN
    chk("single_value", s_max_value, 32'hC0400000);
    chk("single_index", {30'd0, s_max_index}, 32'd1);
`else
    chk("single_value", s_max_value, 32'h40000000);
    chk("single_index", {30'd0, s_max_index}, 32'd2);
`endif
    step();
    chk("single_done", {31'd0, s_out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
